// File: rtl/gain_pkg.sv
// Shared types and helpers for the multi-channel gain stage: FSM states,
// clip counter width and the floor-shift-saturate helper used on the product.
package gain_pkg;

    typedef enum logic [1:0] {S_READ, S_MUL, S_WRITE} state_t;

    localparam int CLIP_CNT_W = 16;
    localparam int SAT_MAX_W  = 64;

    typedef struct packed {
        logic                        clip;
        logic signed [SAT_MAX_W-1:0] val;
    } sat_t;

    // p is the sign-extended product; result is floor(p / 2^frac) clamped to a
    // signed field of 'width' bits, with clip set when the clamp engaged.
    function automatic sat_t sat_shift(input logic signed [2*SAT_MAX_W-1:0] p,
                                       input int unsigned frac,
                                       input int unsigned width);
        logic signed [2*SAT_MAX_W-1:0] y;
        logic signed [2*SAT_MAX_W-1:0] one;
        logic signed [2*SAT_MAX_W-1:0] lim_hi;
        logic signed [2*SAT_MAX_W-1:0] lim_lo;
        sat_t r;
        one    = {{(2*SAT_MAX_W-1){1'b0}}, 1'b1};
        y      = p >>> frac;
        lim_hi = (one << (width - 1)) - one;
        lim_lo = ~lim_hi;
        r.clip = 1'b0;
        r.val  = y[SAT_MAX_W-1:0];
        if (y > lim_hi) begin
            r.clip = 1'b1;
            r.val  = lim_hi[SAT_MAX_W-1:0];
        end else if (y < lim_lo) begin
            r.clip = 1'b1;
            r.val  = lim_lo[SAT_MAX_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/gain_ramp_ctrl.sv
// Gain ramp controller: moves gain_cur toward the latched target by at most
// RAMP_STEP per frame, then latches the new volume as the next target.
module gain_ramp_ctrl #(
    parameter int DATA_SIZE  = 32,
    parameter int RAMP_STEP  = 16,
    parameter int RESET_GAIN = 0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        frame_done,
    input  logic signed [DATA_SIZE-1:0] volume,
    output logic signed [DATA_SIZE-1:0] gain_cur,
    output logic                        ramp_busy
);

    localparam logic signed [DATA_SIZE:0] STEP = (DATA_SIZE+1)'(RAMP_STEP);

    logic signed [DATA_SIZE-1:0] target;
    logic signed [DATA_SIZE:0]   diff;
    logic                        near;

    // One extra bit so target - gain_cur cannot wrap for extreme gains.
    assign diff      = (DATA_SIZE+1)'(target) - (DATA_SIZE+1)'(gain_cur);
    assign near      = (RAMP_STEP == 0) || ((diff <= STEP) && (diff >= -STEP));
    assign ramp_busy = (gain_cur != target);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gain_cur <= DATA_SIZE'(RESET_GAIN);
            target   <= DATA_SIZE'(RESET_GAIN);
        end else if (frame_done) begin
            if (near)
                gain_cur <= target;
            else if (diff > 0)
                gain_cur <= gain_cur + STEP[DATA_SIZE-1:0];
            else
                gain_cur <= gain_cur - STEP[DATA_SIZE-1:0];
            target <= volume;
        end
    end

endmodule

// File: rtl/gain_ramp_mc.sv
// Multi-channel FIFO-to-FIFO volume stage: read, multiply by Q(FRAC_BITS) gain,
// floor/saturate, write; gain ramps once per interleaved frame.
module gain_ramp_mc
    import gain_pkg::*;
#(
    parameter int DATA_SIZE  = 32,
    parameter int FRAC_BITS  = 10,
    parameter int N_CHANNELS = 2,
    parameter int RAMP_STEP  = 16,
    parameter int RESET_GAIN = 0,
    localparam int CH_W      = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic signed [DATA_SIZE-1:0] volume,
    input  logic        [DATA_SIZE-1:0] in_dout,
    input  logic                        in_empty,
    output logic                        in_rd_en,
    output logic        [DATA_SIZE-1:0] out_din,
    input  logic                        out_full,
    output logic                        out_wr_en,
    output logic        [CH_W-1:0]      out_channel,
    output logic signed [DATA_SIZE-1:0] gain_cur,
    output logic                        ramp_busy,
    output logic       [CLIP_CNT_W-1:0] clip_count
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CHANNELS - 1);

    state_t                          state;
    logic signed [DATA_SIZE-1:0]     x_r;
    logic                            clip_r;
    logic signed [2*DATA_SIZE-1:0]   prod;
    logic signed [2*SAT_MAX_W-1:0]   prod_ext;
    sat_t                            sat_res;
    logic                            frame_done;

    assign prod     = (2*DATA_SIZE)'(x_r) * (2*DATA_SIZE)'(gain_cur);
    assign prod_ext = (2*SAT_MAX_W)'(prod);
    assign sat_res  = sat_shift(prod_ext, FRAC_BITS, DATA_SIZE);

    // Reset gates the pop so nothing is consumed while reset is held low.
    assign in_rd_en   = reset && (state == S_READ) && !in_empty;
    assign out_wr_en  = (state == S_WRITE) && !out_full;
    assign frame_done = out_wr_en && (out_channel == LAST_CH);

    // Reset release is expected to be synchronous to clock at system level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_READ;
            x_r         <= '0;
            out_din     <= '0;
            clip_r      <= 1'b0;
            out_channel <= '0;
            clip_count  <= '0;
        end else begin
            case (state)
                S_READ: begin
                    if (in_rd_en) begin
                        x_r   <= in_dout;
                        state <= S_MUL;
                    end
                end
                S_MUL: begin
                    out_din <= sat_res.val[DATA_SIZE-1:0];
                    clip_r  <= sat_res.clip;
                    state   <= S_WRITE;
                end
                S_WRITE: begin
                    if (out_wr_en) begin
                        if (clip_r && (clip_count != '1))
                            clip_count <= clip_count + CLIP_CNT_W'(1);
                        out_channel <= (out_channel == LAST_CH) ? '0
                                       : out_channel + CH_W'(1);
                        state <= S_READ;
                    end
                end
                default: state <= S_READ;
            endcase
        end
    end

    gain_ramp_ctrl #(
        .DATA_SIZE (DATA_SIZE),
        .RAMP_STEP (RAMP_STEP),
        .RESET_GAIN(RESET_GAIN)
    ) u_ctrl (
        .clock     (clock),
        .reset     (reset),
        .frame_done(frame_done),
        .volume    (volume),
        .gain_cur  (gain_cur),
        .ramp_busy (ramp_busy)
    );

endmodule
